// File: rtl/serial_subtractor_64_if.sv
// serial_subtractor_64_if: operand/result handshake bundle for serial_subtractor_64
interface serial_subtractor_64_if #(parameter int WIDTH = 64);
  logic             in_valid, in_ready, out_valid, out_ready, BORROW, OVF;
  logic [WIDTH-1:0] A, B, DIFF;
  modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, DIFF, BORROW, OVF);
  modport slave  (input in_valid, A, B, out_ready, output in_ready, out_valid, DIFF, BORROW, OVF);
endinterface

// File: rtl/serial_subtractor_64.sv
// serial_subtractor_64: multi-cycle A-B as A+~B+1, STEP bits per clock through one look-ahead slice
// Optional signed-overflow output enabled by `define SERIAL_SUB_OVF_EN
module serial_subtractor_64 #(
  parameter int WIDTH = 64,
  parameter int STEP  = 2
) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_64_if.slave bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, diff;
  logic [CW-1:0] cnt;
  logic carry, borrow, ovf, accept, last;
  logic [STEP-1:0] g, p, sum;
  logic [STEP:0] c;
  function automatic logic [STEP:0] lookahead(input logic [STEP-1:0] gg, pp, input logic cin);
    logic [STEP:0] cc;
    cc[0] = cin;
    for (int i = 0; i < STEP; i++) cc[i+1] = gg[i] | (pp[i] & cc[i]);
    return cc;
  endfunction
  always_comb begin
    g      = a_sh[STEP-1:0] & b_sh[STEP-1:0];
    p      = a_sh[STEP-1:0] ^ b_sh[STEP-1:0];
    c      = lookahead(g, p, carry);
    sum    = p ^ c[STEP-1:0];
    accept = (state == IDLE) & bus.in_valid;
    last   = cnt == CW'(N - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (bus.in_valid ? RUN : IDLE)
             : state == RUN  ? (last ? DONE : RUN)
             : (bus.out_ready ? IDLE : DONE);
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == DONE;
    bus.DIFF      = diff;
    bus.BORROW    = borrow;
    bus.OVF       = ovf;
  end
  // Sum bits enter at the top of diff so the LSB slice ends up at bit 0 after N steps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      diff   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      borrow <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.A;
      b_sh  <= ~bus.B;
      carry <= 1'b1;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> STEP;
      b_sh  <= b_sh >> STEP;
      diff  <= {sum, diff[WIDTH-1:STEP]};
      carry <= c[STEP];
      cnt   <= last ? '0 : cnt + CW'(1);
      if (last) borrow <= ~c[STEP];
    end
`ifdef SERIAL_SUB_OVF_EN
  logic sa, sb;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa  <= 1'b0;
      sb  <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      sa <= bus.A[WIDTH-1];
      sb <= bus.B[WIDTH-1];
    end else if (state == RUN && last) ovf <= (sa ^ sb) & (sum[STEP-1] ^ sa);
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_subtractor_64.sv
// tb_serial_subtractor_64: directed-vector bench with immediate assertions
module tb_serial_subtractor_64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  serial_subtractor_64_if #(.WIDTH(64)) bus ();
  serial_subtractor_64 #(.WIDTH(64), .STEP(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
`ifdef SERIAL_SUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic op(input string tag, input logic [63:0] a, input logic [63:0] b,
                    input logic [63:0] exp_d, input logic exp_b, input logic exp_o,
                    input int hold, input bit noise);
    int n;
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 100) begin
      if (noise) begin
        chk({tag, ".busy_in_ready"}, 64'(bus.in_ready), 64'd0);
        bus.in_valid = n[0];
        bus.A = {$urandom, $urandom};
        bus.B = {$urandom, $urandom};
      end
      @(posedge clk);
      #1 n++;
    end
    bus.in_valid = 1'b0;
    chk({tag, ".latency"}, 64'(n), 64'd33);
    chk({tag, ".diff"}, bus.DIFF, exp_d);
    chk({tag, ".borrow"}, 64'(bus.BORROW), 64'(exp_b));
    chk({tag, ".ovf"}, 64'(bus.OVF), 64'(exp_o));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 chk({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, ".hold_diff"}, bus.DIFF, exp_d);
      chk({tag, ".hold_borrow"}, 64'(bus.BORROW), 64'(exp_b));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk({tag, ".post_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, ".post_out_valid"}, 64'(bus.out_valid), 64'd0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #12;
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.diff", bus.DIFF, 64'd0);
    chk("rst.borrow", 64'(bus.BORROW), 64'd0);
    chk("rst.ovf", 64'(bus.OVF), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    op("basic", 64'd100, 64'd58, 64'd42, 1'b0, 1'b0, 0, 1'b0);
    op("borrow", 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0, 1'b0);
    op("sovf", 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, OVF_ON, 0, 1'b0);
    op("chain", 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0, 1'b0, 0, 1'b0);
    op("bp", 64'h0000_0001_0000_0000, 64'd1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 10, 1'b1);
    @(negedge clk);
    bus.A = 64'd77;
    bus.B = 64'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst.diff", bus.DIFF, 64'd0);
    chk("midrst.borrow", 64'(bus.BORROW), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    op("after_rst", 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
